// File: rtl/sm_step_gen_if.sv
// Command/status bundle between a motion controller
// and the multi-channel step pulse generator.
interface sm_step_gen_if #(
    parameter int CH    = 2,
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic                   enable;
    logic [CH-1:0]          cmd_valid;
    logic [CH-1:0]          cmd_ready;
    logic [CH*CNT_W-1:0]    cmd_steps;
    logic [CH*PER_W-1:0]    cmd_period;
    logic [CH-1:0]          cmd_dir;
    logic [CH-1:0]          abort;
    logic [CH-1:0]          step;
    logic [CH-1:0]          dir;
    logic [CH-1:0]          busy;
    logic [CH-1:0]          done;
    logic [CH*CNT_W-1:0]    remaining;

    modport master (
        output enable, cmd_valid, cmd_steps, cmd_period,
        output cmd_dir, abort,
        input  cmd_ready, step, dir, busy, done, remaining
    );

    modport slave (
        input  enable, cmd_valid, cmd_steps, cmd_period,
        input  cmd_dir, abort,
        output cmd_ready, step, dir, busy, done, remaining
    );
endinterface

// File: rtl/sm_step_gen.sv
// Multi-channel stepper pulse train generator: each channel
// emits N pulses of HI_CYC high time at a P-cycle period.
module sm_step_gen #(
    parameter int CH     = 2,
    parameter int CNT_W  = 16,
    parameter int PER_W  = 16,
    parameter int HI_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    sm_step_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } st_t;

    localparam logic [PER_W-1:0] HI_LEN  = PER_W'(HI_CYC);
    localparam logic [PER_W-1:0] HI_LAST = PER_W'(HI_CYC - 1);
    localparam logic [PER_W-1:0] P_MIN   = PER_W'(HI_CYC + 1);

    st_t              st_q   [CH];
    st_t              st_d   [CH];
    logic [PER_W-1:0] cnt_q  [CH];
    logic [PER_W-1:0] cnt_d  [CH];
    logic [PER_W-1:0] low_q  [CH];
    logic [PER_W-1:0] low_d  [CH];
    logic [CNT_W-1:0] rem_q  [CH];
    logic [CNT_W-1:0] rem_d  [CH];
    logic             dir_q  [CH];
    logic             dir_d  [CH];
    logic             done_q [CH];
    logic             done_d [CH];
    logic [PER_W-1:0] per_c  [CH];
    logic [CNT_W-1:0] n_c    [CH];

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                st_q[c]   <= IDLE;
                cnt_q[c]  <= '0;
                low_q[c]  <= '0;
                rem_q[c]  <= '0;
                dir_q[c]  <= 1'b0;
                done_q[c] <= 1'b0;
            end else begin
                st_q[c]   <= st_d[c];
                cnt_q[c]  <= cnt_d[c];
                low_q[c]  <= low_d[c];
                rem_q[c]  <= rem_d[c];
                dir_q[c]  <= dir_d[c];
                done_q[c] <= done_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            st_d[c]   = st_q[c];
            cnt_d[c]  = cnt_q[c];
            low_d[c]  = low_q[c];
            rem_d[c]  = rem_q[c];
            dir_d[c]  = dir_q[c];
            done_d[c] = 1'b0;
            n_c[c]    = bus.cmd_steps[c*CNT_W +: CNT_W];
            per_c[c]  = bus.cmd_period[c*PER_W +: PER_W];
            if (per_c[c] < P_MIN)
                per_c[c] = P_MIN;

            // abort bypasses enable so a paused axis can still be stopped
            if (bus.abort[c] && st_q[c] != IDLE) begin
                st_d[c]   = IDLE;
                done_d[c] = 1'b1;
            end else if (bus.enable) begin
                unique case (st_q[c])
                    IDLE: begin
                        if (bus.cmd_valid[c]) begin
                            dir_d[c] = bus.cmd_dir[c];
                            low_d[c] = per_c[c] - HI_LEN;
                            cnt_d[c] = '0;
                            if (n_c[c] == '0) begin
                                rem_d[c]  = '0;
                                done_d[c] = 1'b1;
                            end else begin
                                rem_d[c] = n_c[c] - 1'b1;
                                st_d[c]  = HIGH;
                            end
                        end
                    end
                    HIGH: begin
                        if (cnt_q[c] == HI_LAST) begin
                            st_d[c]  = LOW;
                            cnt_d[c] = '0;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt_q[c] == low_q[c] - 1'b1) begin
                            cnt_d[c] = '0;
                            if (rem_q[c] != '0) begin
                                st_d[c]  = HIGH;
                                rem_d[c] = rem_q[c] - 1'b1;
                            end else begin
                                st_d[c]   = IDLE;
                                done_d[c] = 1'b1;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                    default: st_d[c] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.cmd_ready = '0;
        bus.step      = '0;
        bus.dir       = '0;
        bus.busy      = '0;
        bus.done      = '0;
        bus.remaining = '0;
        for (int c = 0; c < CH; c++) begin
            bus.cmd_ready[c] = (st_q[c] == IDLE) && !rst;
            bus.step[c]      = (st_q[c] == HIGH);
            bus.dir[c]       = dir_q[c];
            bus.busy[c]      = (st_q[c] != IDLE);
            bus.done[c]      = done_q[c];
            bus.remaining[c*CNT_W +: CNT_W] = rem_q[c];
        end
    end
endmodule

// File: tb/tb_sm_step_gen.sv
// Bench for sm_step_gen: directed scenarios plus random traffic
// checked each cycle against an elapsed-time reference model.
module tb_sm_step_gen;
    localparam int CH    = 2;
    localparam int CNT_W = 6;
    localparam int PER_W = 8;
    localparam int HI    = 4;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    sm_step_gen_if #(.CH(CH), .CNT_W(CNT_W), .PER_W(PER_W)) bus ();

    sm_step_gen #(
        .CH(CH), .CNT_W(CNT_W), .PER_W(PER_W), .HI_CYC(HI)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    bit m_act  [CH];
    bit m_dir  [CH];
    bit m_done [CH];
    int m_e    [CH];
    int m_n    [CH];
    int m_p    [CH];
    int m_rem  [CH];

    int cyc_no;
    int done_at;
    int rem_at;

    function automatic int peff(int p);
        return (p < HI + 1) ? HI + 1 : p;
    endfunction

    task automatic chk(string tag, int c, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s ch%0d cyc%0d observed=%0d expected=%0d",
                   tag, c, cyc_no, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.enable     = 1'b1;
        bus.cmd_valid  = '0;
        bus.cmd_steps  = '0;
        bus.cmd_period = '0;
        bus.cmd_dir    = '0;
        bus.abort      = '0;
    endtask

    task automatic cmd(int c, int n, int p, bit d);
        bus.cmd_valid[c] = 1'b1;
        bus.cmd_steps[c*CNT_W +: CNT_W]  = CNT_W'(n);
        bus.cmd_period[c*PER_W +: PER_W] = PER_W'(p);
        bus.cmd_dir[c] = d;
    endtask

    // compare this cycle's outputs, then advance the model by one edge
    task automatic tick();
        int e_step, e_rem;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            e_step = (m_act[c] && (m_e[c] % m_p[c]) < HI) ? 1 : 0;
            e_rem  = m_act[c] ? m_n[c] - 1 - m_e[c] / m_p[c] : m_rem[c];
            chk("step", c, int'(bus.step[c]), e_step);
            chk("busy", c, int'(bus.busy[c]), int'(m_act[c]));
            chk("done", c, int'(bus.done[c]), int'(m_done[c]));
            chk("dir", c, int'(bus.dir[c]), int'(m_dir[c]));
            chk("ready", c, int'(bus.cmd_ready[c]),
                int'(!rst && !m_act[c]));
            chk("remaining", c,
                int'(bus.remaining[c*CNT_W +: CNT_W]), e_rem);
        end
        if (bus.done[0] && done_at < 0) begin
            done_at = cyc_no;
            rem_at  = int'(bus.remaining[CNT_W-1:0]);
        end
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_act[c] = 0; m_dir[c] = 0; m_done[c] = 0;
                m_e[c] = 0; m_rem[c] = 0; m_n[c] = 1; m_p[c] = HI + 1;
            end else begin
                m_done[c] = 0;
                if (m_act[c] && bus.abort[c]) begin
                    m_rem[c]  = m_n[c] - 1 - m_e[c] / m_p[c];
                    m_act[c]  = 0;
                    m_done[c] = 1;
                end else if (bus.enable) begin
                    if (m_act[c]) begin
                        m_e[c]++;
                        if (m_e[c] == m_n[c] * m_p[c]) begin
                            m_act[c] = 0; m_rem[c] = 0; m_done[c] = 1;
                        end
                    end else if (bus.cmd_valid[c]) begin
                        m_dir[c] = bus.cmd_dir[c];
                        m_n[c] = int'(bus.cmd_steps[c*CNT_W +: CNT_W]);
                        m_p[c] = peff(int'(bus.cmd_period[c*PER_W +: PER_W]));
                        m_e[c] = 0;
                        m_rem[c] = 0;
                        if (m_n[c] == 0) m_done[c] = 1;
                        else m_act[c] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic start_scn();
        clear_in();
        rst = 1'b0;
        cyc_no  = 0;
        done_at = -1;
        rem_at  = -1;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            m_act[c] = 0; m_dir[c] = 0; m_done[c] = 0;
            m_e[c] = 0; m_rem[c] = 0; m_n[c] = 1; m_p[c] = HI + 1;
        end
        clear_in();
        rst = 1'b1;
        cyc_no = 0; done_at = -1; rem_at = -1;
        repeat (3) tick();

        // basic train: N=3, P=10
        start_scn();
        cmd(0, 3, 10, 1'b1);
        tick();
        clear_in();
        repeat (34) tick();
        chk("basic_done_cycle", 0, done_at, 31);

        // period clamp: P=3 behaves as 5
        start_scn();
        cmd(0, 2, 3, 1'b0);
        tick();
        clear_in();
        repeat (14) tick();
        chk("clamp_done_cycle", 0, done_at, 11);

        // abort in cycle 12, new command in cycle 13
        start_scn();
        cmd(0, 5, 10, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 1) clear_in();
            if (i == 12) bus.abort[0] = 1'b1;
            if (i == 13) begin
                clear_in();
                cmd(0, 1, 6, 1'b0);
            end
            if (i == 14) clear_in();
            tick();
        end
        chk("abort_done_cycle", 0, done_at, 13);
        chk("abort_remaining", 0, rem_at, 3);
        repeat (5) tick();

        // pause cycles 6..15
        start_scn();
        cmd(0, 2, 10, 1'b1);
        for (int i = 0; i < 36; i++) begin
            if (i == 1) clear_in();
            bus.enable = !(i >= 6 && i <= 15);
            tick();
        end
        chk("pause_done_cycle", 0, done_at, 31);

        // same-cycle accept: ch0 N=0, ch1 N=4
        start_scn();
        cmd(0, 0, 10, 1'b1);
        cmd(1, 4, 7, 1'b1);
        tick();
        clear_in();
        repeat (32) tick();
        chk("zero_done_cycle", 0, done_at, 1);

        // reset in cycle 7 of a train
        start_scn();
        cmd(0, 4, 8, 1'b1);
        cmd(1, 3, 6, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i == 1) clear_in();
            rst = (i == 7);
            tick();
        end
        chk("reset_no_done", 0, done_at, -1);

        // counter limits
        start_scn();
        cmd(0, 63, 5, 1'b1);
        tick();
        clear_in();
        repeat (320) tick();
        chk("max_n_done_cycle", 0, done_at, 316);

        start_scn();
        cmd(0, 3, 255, 1'b0);
        tick();
        clear_in();
        repeat (770) tick();
        chk("max_p_done_cycle", 0, done_at, 766);

        // random traffic
        start_scn();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < CH; c++) begin
                bus.cmd_valid[c] = ($urandom_range(0, 3) == 0);
                bus.cmd_steps[c*CNT_W +: CNT_W] =
                    CNT_W'($urandom_range(0, 5));
                bus.cmd_period[c*PER_W +: PER_W] =
                    PER_W'($urandom_range(1, 14));
                bus.cmd_dir[c] = 1'($urandom_range(0, 1));
                bus.abort[c] = ($urandom_range(0, 59) == 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
